universal_shift_register_usr_param: RTL and testbench

Parametrised successor to the fixed-width universal shift register. It adds a configurable WIDTH, rotate and arithmetic-shift modes, and a multi-cycle burst-shift mode with a busy/done handshake. It sits in the serial/parallel data-path library as a drop-in replacement for the per-width USR instances.

---
 rtl/universal_shift_register_usr_param.sv | 128 ++++++++++++
 tb/tb_universal_shift_register_usr_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register_usr_param.sv
// Parametrised universal shift register: shifts, rotates, arithmetic shift, parallel load,
// and a multi-cycle burst shift with a busy/done handshake.
module universal_shift_register_usr_param #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int              COUNT_W     = $clog2(WIDTH + 1)
) (
    input  logic               Clk_In,
    input  logic               Reset_In,
    input  logic               Enable_In,
    input  logic [2:0]         USR_Operation_Select_In,
    input  logic               Serial_Left_Side_Data_In,
    input  logic               Serial_Right_Side_Data_In,
    input  logic [WIDTH-1:0]   Parallel_Data_In,
    input  logic [COUNT_W-1:0] Shift_Count_In,
    input  logic               Burst_Direction_In,
    output logic               Serial_Left_Side_Data_Out,
    output logic               Serial_Right_Side_Data_Out,
    output logic [WIDTH-1:0]   Parallel_Data_Out,
    output logic               Busy_Out,
    output logic               Done_Out
);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_SHL   = 3'd1,
        OP_SHR   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_ROL   = 3'd4,
        OP_ROR   = 3'd5,
        OP_ASR   = 3'd6,
        OP_BURST = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(WIDTH);
    localparam logic [COUNT_W-1:0] ONE_COUNT = COUNT_W'(1);

    state_e             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [COUNT_W-1:0] r_remaining;
    logic               r_dir;
    logic               r_done;

    state_e             w_state_next;
    logic [WIDTH-1:0]   w_data_next;
    logic [COUNT_W-1:0] w_remaining_next;
    logic               w_dir_next;
    logic               w_done_next;
    logic [COUNT_W-1:0] w_count_sat;
    logic [WIDTH-1:0]   w_shl;
    logic [WIDTH-1:0]   w_shr;

    assign w_shl       = {r_data[WIDTH-2:0], Serial_Right_Side_Data_In};
    assign w_shr       = {Serial_Left_Side_Data_In, r_data[WIDTH-1:1]};
    assign w_count_sat = (Shift_Count_In > MAX_COUNT) ? MAX_COUNT : Shift_Count_In;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_data_next      = r_data;
        w_remaining_next = r_remaining;
        w_dir_next       = r_dir;
        w_done_next      = 1'b0;

        if (Enable_In) begin
            unique case (r_state)
                ST_IDLE: begin
                    unique case (op_e'(USR_Operation_Select_In))
                        OP_NOP:  w_data_next = r_data;
                        OP_SHL:  w_data_next = w_shl;
                        OP_SHR:  w_data_next = w_shr;
                        OP_LOAD: w_data_next = Parallel_Data_In;
                        OP_ROL:  w_data_next = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                        OP_ROR:  w_data_next = {r_data[0], r_data[WIDTH-1:1]};
                        OP_ASR:  w_data_next = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
                        OP_BURST: begin
                            // Zero-length burst completes immediately without ever raising busy.
                            if (w_count_sat == '0) begin
                                w_done_next = 1'b1;
                            end else begin
                                w_state_next     = ST_BUSY;
                                w_remaining_next = w_count_sat;
                                w_dir_next       = Burst_Direction_In;
                            end
                        end
                    endcase
                end
                ST_BUSY: begin
                    w_data_next      = r_dir ? w_shr : w_shl;
                    w_remaining_next = r_remaining - ONE_COUNT;
                    if (r_remaining == ONE_COUNT) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state     <= ST_IDLE;
            r_data      <= RESET_VALUE;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_data      <= w_data_next;
            r_remaining <= w_remaining_next;
            r_dir       <= w_dir_next;
            r_done      <= w_done_next;
        end
    end

    assign Parallel_Data_Out          = r_data;
    assign Serial_Left_Side_Data_Out  = r_data[WIDTH-1];
    assign Serial_Right_Side_Data_Out = r_data[0];
    assign Busy_Out                   = (r_state == ST_BUSY);
    assign Done_Out                   = r_done;

endmodule

// File: tb/tb_universal_shift_register_usr_param.sv
// Self-checking bench for universal_shift_register_usr_param at WIDTH=8: vector table,
// directed burst/reset sequences, and random stimulus against a behavioural model.
module tb_universal_shift_register_usr_param;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = $clog2(WIDTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [2:0]         op;
    logic               sl;
    logic               sr;
    logic [WIDTH-1:0]   pd;
    logic [COUNT_W-1:0] cnt;
    logic               dir;
    logic               msb_o;
    logic               lsb_o;
    logic [WIDTH-1:0]   data_o;
    logic               busy_o;
    logic               done_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: register value, shifts still owed by a burst, direction, done pulse.
    int m_reg;
    int m_left;
    bit m_dir;
    bit m_done;

    universal_shift_register_usr_param #(.WIDTH(WIDTH)) dut (
        .Clk_In                     (clk),
        .Reset_In                   (rst),
        .Enable_In                  (en),
        .USR_Operation_Select_In    (op),
        .Serial_Left_Side_Data_In   (sl),
        .Serial_Right_Side_Data_In  (sr),
        .Parallel_Data_In           (pd),
        .Shift_Count_In             (cnt),
        .Burst_Direction_In         (dir),
        .Serial_Left_Side_Data_Out  (msb_o),
        .Serial_Right_Side_Data_Out (lsb_o),
        .Parallel_Data_Out          (data_o),
        .Busy_Out                   (busy_o),
        .Done_Out                   (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] op;
        logic       sl;
        logic       sr;
        logic [7:0] pd;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_state(input string tag, input logic [7:0] d, input logic b, input logic dn);
        logic [7:0] dv;
        dv = d;
        check({tag, " data"}, 32'(data_o), 32'(dv));
        check({tag, " serial"}, {30'd0, msb_o, lsb_o}, {30'd0, dv[7], dv[0]});
        check({tag, " busy"}, 32'(busy_o), 32'(b));
        check({tag, " done"}, 32'(done_o), 32'(dn));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] o, input logic l, input logic r,
                         input logic [7:0] p, input logic [COUNT_W-1:0] c, input logic d);
        en = e; op = o; sl = l; sr = r; pd = p; cnt = c; dir = d;
    endtask

    // Next-state of the model from the current inputs, using plain integer arithmetic.
    task automatic model_step();
        int n;
        int c;
        n      = m_reg;
        m_done = 1'b0;
        if (en) begin
            if (m_left > 0) begin
                n = m_dir ? ((m_reg >> 1) + (int'(sl) * 128)) : ((m_reg * 2) + int'(sr));
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else begin
                case (op)
                    3'd1: n = m_reg * 2 + int'(sr);
                    3'd2: n = (m_reg >> 1) + int'(sl) * 128;
                    3'd3: n = int'(pd);
                    3'd4: n = m_reg * 2 + m_reg / 128;
                    3'd5: n = (m_reg >> 1) + (m_reg % 2) * 128;
                    3'd6: n = (m_reg >> 1) + (m_reg & 128);
                    3'd7: begin
                        c = (int'(cnt) > WIDTH) ? WIDTH : int'(cnt);
                        if (c == 0) m_done = 1'b1;
                        else begin
                            m_left = c;
                            m_dir  = dir;
                        end
                    end
                    default: n = m_reg;
                endcase
            end
        end
        m_reg = n % 256;
    endtask

    initial begin
        int busy_cycles;
        int guard;

        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, '0, 1'b0);
        rst = 1'b1;
        #3;
        expect_state("reset", 8'h00, 1'b0, 1'b0);
        #9 rst = 1'b0;
        tick();

        // Table: rotate/arith-shift plan plus plain shifts, NOP and a disabled load.
        vecs[0]  = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h81, 8'h81};
        vecs[1]  = '{1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 8'h03};
        vecs[2]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 8'h81};
        vecs[3]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 8'hC0};
        vecs[4]  = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h80, 8'h80};
        vecs[5]  = '{1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'hC0};
        vecs[6]  = '{1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'hE0};
        vecs[7]  = '{1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'hF0};
        vecs[8]  = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h40, 8'h40};
        vecs[9]  = '{1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'h20};
        vecs[10] = '{1'b1, 3'd1, 1'b0, 1'b1, 8'h00, 8'h41};
        vecs[11] = '{1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 8'hA0};
        vecs[12] = '{1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 8'hA0};
        vecs[13] = '{1'b0, 3'd3, 1'b0, 1'b0, 8'hFF, 8'hA0};
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].en, vecs[i].op, vecs[i].sl, vecs[i].sr, vecs[i].pd, '0, 1'b0);
            tick();
            expect_state($sformatf("vec%0d", i), vecs[i].exp, 1'b0, 1'b0);
        end

        // Burst left 3 with a load attempted mid-burst and on the completion edge.
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h0F, '0, 1'b0);             tick(); expect_state("bA load", 8'h0F, 0, 0);
        drive(1'b1, 3'd7, 1'b0, 1'b0, 8'h00, COUNT_W'(3), 1'b0);    tick(); expect_state("bA accept", 8'h0F, 1, 0);
        drive(1'b1, 3'd3, 1'b0, 1'b1, 8'hFF, '0, 1'b0);             tick(); expect_state("bA s1", 8'h1F, 1, 0);
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'hFF, '0, 1'b0);             tick(); expect_state("bA s2", 8'h3E, 1, 0);
        drive(1'b1, 3'd3, 1'b0, 1'b1, 8'hFF, '0, 1'b0);             tick(); expect_state("bA s3", 8'h7D, 0, 1);
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h55, '0, 1'b0);             tick(); expect_state("bA next", 8'h55, 0, 0);

        // Burst left 4 with enable low for two cycles after the first shift.
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h01, '0, 1'b0);             tick();
        drive(1'b1, 3'd7, 1'b0, 1'b0, 8'h00, COUNT_W'(4), 1'b0);    tick(); expect_state("bB accept", 8'h01, 1, 0);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, '0, 1'b0);             tick(); expect_state("bB s1", 8'h02, 1, 0);
        en = 1'b0; tick(); expect_state("bB hold1", 8'h02, 1, 0);
        tick(); expect_state("bB hold2", 8'h02, 1, 0);
        en = 1'b1; tick(); expect_state("bB s2", 8'h04, 1, 0);
        tick(); expect_state("bB s3", 8'h08, 1, 0);
        tick(); expect_state("bB s4", 8'h10, 0, 1);
        en = 1'b0; tick(); expect_state("bB done clr", 8'h10, 0, 0);

        // Zero count, then saturating count 12 -> 8 shifts.
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h5A, '0, 1'b0);             tick();
        drive(1'b1, 3'd7, 1'b0, 1'b0, 8'h00, COUNT_W'(0), 1'b0);    tick(); expect_state("c0 accept", 8'h5A, 0, 1);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, '0, 1'b0);             tick(); expect_state("c0 after", 8'h5A, 0, 0);
        drive(1'b1, 3'd7, 1'b0, 1'b1, 8'h00, COUNT_W'(12), 1'b0);   tick();
        drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00, '0, 1'b0);
        busy_cycles = 0;
        guard       = 0;
        while (busy_o === 1'b1 && guard < 20) begin
            busy_cycles++;
            guard++;
            tick();
        end
        check("sat busy cycles", 32'(busy_cycles), 32'd8);
        expect_state("sat end", 8'hFF, 0, 1);

        // Burst right 5 interrupted by an asynchronous reset between edges.
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'hA5, '0, 1'b0);             tick();
        drive(1'b1, 3'd7, 1'b0, 1'b0, 8'h00, COUNT_W'(5), 1'b1);    tick(); expect_state("bD accept", 8'hA5, 1, 0);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, '0, 1'b0);             tick(); expect_state("bD s1", 8'h52, 1, 0);
        tick(); expect_state("bD s2", 8'h29, 1, 0);
        #2 rst = 1'b1;
        #1 expect_state("bD async rst", 8'h00, 0, 0);
        tick(); expect_state("bD in rst", 8'h00, 0, 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state($sformatf("bD post%0d", i), 8'h00, 0, 0);
        end
        drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h3C, '0, 1'b0);             tick(); expect_state("bD reload", 8'h3C, 0, 0);

        // Random stimulus against the behavioural model.
        m_reg = 8'h3C; m_left = 0; m_dir = 1'b0; m_done = 1'b0;
        for (int i = 0; i < 800; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            op  = 3'($urandom_range(0, 7));
            sl  = 1'($urandom);
            sr  = 1'($urandom);
            pd  = 8'($urandom);
            cnt = COUNT_W'($urandom_range(0, 15));
            dir = 1'($urandom);
            model_step();
            tick();
            expect_state($sformatf("rnd%0d", i), 8'(m_reg), (m_left > 0), m_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
